// File: rtl/r_type_issue_unit_pkg.sv
// Shared definitions for the R-type issue unit: opcode and funct encodings
// of the supported operations, the instruction field layout, the buffer
// depth and the legality decode used by the issue logic.
package r_type_issue_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } r_instr_t;

    // True when the opcode/funct pair is one of the supported R-type operations.
    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        logic ok;
        if (opcode != OP_RTYPE) begin
            ok = 1'b0;
        end else begin
            case (funct)
                FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU,
                FN_AND, FN_OR, FN_SUB, FN_SLTU: ok = 1'b1;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/r_type_issue_unit_fifo.sv
// instr_fifo2: two-entry first-in first-out buffer of 32-bit instruction words.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_flush             synchronous clear; overrides push and pop
//   i_push, i_data      write request and word (ignored when full)
//   i_pop               remove head (ignored when empty)
//   o_data              current head word
//   o_full, o_empty     occupancy flags
module instr_fifo2
    import r_type_issue_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [31:0] i_data,
    input  logic        i_pop,
    output logic [31:0] o_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    logic [31:0] r_mem [0:FIFO_DEPTH-1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;

    // A full buffer refuses a push even if the head leaves in the same cycle.
    assign w_push  = i_push && (r_count != DEPTH_C) && !i_flush;
    assign w_pop   = i_pop && (r_count != 2'd0) && !i_flush;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/r_type_issue_unit.sv
// r_type_issue_unit: buffers MIPS instruction words and issues supported
// R-type operations to the ALU stage; unsupported words are dropped with a
// one-cycle illegal pulse.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            synchronous clear of buffered words
//   instr_valid/instr_ready/instr    upstream handshake and word
//   issue_valid/issue_ready          ALU-stage handshake
//   funct, rs_num, rt_num, rd_num, shamt   issued operation fields (0 when idle)
//   illegal                          head discarded as unsupported this cycle
//   issued_count                     wrapping count of issue handshakes
//   illegal_count                    saturating count of discarded words
module r_type_issue_unit
    import r_type_issue_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [5:0]  funct,
    output logic [4:0]  rs_num,
    output logic [4:0]  rt_num,
    output logic [4:0]  rd_num,
    output logic [4:0]  shamt,
    output logic        illegal,
    output logic [15:0] issued_count,
    output logic [7:0]  illegal_count
);

    logic [31:0] w_head_word;
    r_instr_t    w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_issue_valid;
    logic        w_illegal;
    logic        w_issue_fire;
    logic [15:0] r_issued_count;
    logic [7:0]  r_illegal_count;

    // rst_n gates readiness directly so the port is low for the whole reset.
    assign instr_ready = rst_n && !w_full && !flush;
    assign w_push      = instr_valid && instr_ready;
    assign w_head      = r_instr_t'(w_head_word);

    instr_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (instr),
        .i_pop   (w_pop),
        .o_data  (w_head_word),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head decode: present a legal head, flag an illegal one, zero fields otherwise.
    always_comb begin
        w_issue_valid = 1'b0;
        w_illegal     = 1'b0;
        funct         = 6'd0;
        rs_num        = 5'd0;
        rt_num        = 5'd0;
        rd_num        = 5'd0;
        shamt         = 5'd0;
        if (!w_empty && !flush) begin
            if (is_legal(w_head.opcode, w_head.funct)) begin
                w_issue_valid = 1'b1;
                funct         = w_head.funct;
                rs_num        = w_head.rs;
                rt_num        = w_head.rt;
                rd_num        = w_head.rd;
                shamt         = w_head.shamt;
            end else begin
                w_illegal = 1'b1;
            end
        end else begin
            w_issue_valid = 1'b0;
        end
    end

    assign issue_valid  = w_issue_valid;
    assign illegal      = w_illegal;
    assign w_issue_fire = w_issue_valid && issue_ready;
    // An illegal head leaves unconditionally; a legal one waits for the ALU.
    assign w_pop        = w_illegal || w_issue_fire;

    // Issue and discard counters; both flags are already low during flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_count  <= 16'd0;
            r_illegal_count <= 8'd0;
        end else begin
            if (w_issue_fire) begin
                r_issued_count <= r_issued_count + 16'd1;
            end
            if (w_illegal && (r_illegal_count != 8'hFF)) begin
                r_illegal_count <= r_illegal_count + 8'd1;
            end
        end
    end

    assign issued_count  = r_issued_count;
    assign illegal_count = r_illegal_count;

endmodule

// File: doc/r_type_issue_unit.md
R_TYPE_ISSUE_UNIT -- requirements
Module: r_type_issue_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous clear of buffered instructions.
REQ-005 instr_valid  input  1  upstream instruction word valid.
REQ-006 instr_ready  output  1  block accepts instr this cycle.
REQ-007 instr  input  32  MIPS word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-008 issue_valid  output  1  decoded legal R-type operation presented to ALU stage.
REQ-009 issue_ready  input  1  ALU stage accepts the issued operation.
REQ-010 funct  output  6  ALU select code, the same code space the ALU result mux decodes.
REQ-011 rs_num, rt_num, rd_num, shamt  output  5 each  register numbers and shift amount of the issued operation.
REQ-012 illegal  output  1  one-cycle pulse: head instruction discarded as unsupported.
REQ-013 issued_count  output  16  count of completed issues.
REQ-014 illegal_count  output  8  count of discarded instructions.

Function
REQ-015 Legal = opcode 6'b000000 AND funct in {000000 sll, 000010 srl, 000011 sra, 100000 add, 100001 addu, 100100 and, 100101 or, 100010 sub, 101011 sltu}; all else illegal.
REQ-016 Instructions SHALL be buffered in a 2-entry FIFO; push on instr_valid && instr_ready.
REQ-017 instr_ready SHALL be 1 iff FIFO occupancy < 2 and flush = 0; no push when full, even with a same-cycle pop.
REQ-018 Word accepted at edge N into an empty FIFO SHALL be presented (issue_valid or illegal) in cycle N+1; latency 1 cycle.
REQ-019 Legal head: issue_valid = 1 with fields from head; pop at the edge where issue_valid && issue_ready.
REQ-020 Outputs funct/rs_num/rt_num/rd_num/shamt SHALL stay stable while issue_valid = 1 and issue_ready = 0.
REQ-021 Illegal head: issue_valid = 0, illegal = 1 for exactly that cycle, head popped at next edge regardless of issue_ready.
REQ-022 Back-to-back illegal heads SHALL each produce a separate one-cycle illegal pulse.
REQ-023 Output fields SHALL be 0 whenever issue_valid = 0.
REQ-024 issued_count SHALL increment on each issue handshake, wrapping 16'hFFFF -> 0.
REQ-025 illegal_count SHALL increment on each illegal pulse, saturating at 8'hFF.
REQ-026 flush = 1 SHALL empty the FIFO at the next edge, suppress issue_valid and illegal in the flush cycle, and leave counters unchanged; flush overrides push and pop.
REQ-027 FIFO order SHALL be strict first-in first-out; simultaneous push and pop with occupancy 1 keeps occupancy 1.

Reset
REQ-028 rst_n = 0 SHALL immediately clear FIFO occupancy, pointers, both counters; issue_valid = 0, illegal = 0, instr_ready = 0 during reset.
REQ-029 Reset asserted mid-issue SHALL discard the pending operation with no count change; after release the block is empty and instr_ready = 1 the first cycle.

Structure
REQ-030 A shared package SHALL hold the nine funct constants, the R-type opcode constant, and FIFO depth 2.
REQ-031 The FIFO SHALL be one sub-module, instr_fifo2 (32-bit, depth 2, push/pop/flush, full/empty).

Verification
REQ-032 Reset, then push 32'h00851020 (add rd=2 rs=4 rt=5) with issue_ready=1 -> next cycle issue_valid=1, funct=100000, rs_num=4, rt_num=5, rd_num=2; issued_count=1.
REQ-033 issue_ready=0, push three legal words -> first two accepted, instr_ready=0 on third; outputs stable; release -> issued in order, issued_count=2.
REQ-034 Push 32'h8C000000 (lw) then 32'h00000001 (funct 000001) -> two one-cycle illegal pulses, no issue_valid, illegal_count=2.
REQ-035 FIFO holds 2 entries, assert flush one cycle -> issue_valid=0 next cycle, counters unchanged, instr_ready=1 after.
REQ-036 Preload issued_count to 16'hFFFF via 65535 issues then one more -> 16'h0000; 256 illegal words -> illegal_count stays 8'hFF.
REQ-037 Assert rst_n=0 mid-cycle while issue_valid=1 -> issue_valid falls without clock edge; all counts 0 after release.
